// File: rtl/stage3_pkg.sv
// Shared definitions for the MIPS execute stage: widths, ALU function codes,
// and the EX/MEM pipeline register payload.
package stage3_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned SP_W       = 8;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned FN_W       = 5;
  localparam int unsigned IMM_BIT    = 5;

  typedef logic [FN_W-1:0] alu_fn_t;

  localparam alu_fn_t FN_ADD = 5'b00100;
  localparam alu_fn_t FN_SUB = 5'b00101;
  localparam alu_fn_t FN_MUL = 5'b00110;
  localparam alu_fn_t FN_DIV = 5'b00111;
  localparam alu_fn_t FN_AND = 5'b01000;
  localparam alu_fn_t FN_OR  = 5'b01001;
  localparam alu_fn_t FN_NOR = 5'b01010;
  localparam alu_fn_t FN_XOR = 5'b01011;
  localparam alu_fn_t FN_SLL = 5'b11000;
  localparam alu_fn_t FN_SRL = 5'b11001;
  localparam alu_fn_t FN_SLA = 5'b11010;
  localparam alu_fn_t FN_SRA = 5'b11011;

  // EX/MEM pipeline register contents
  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic                  br_ex;
    logic [DATA_W-1:0]     data1;
    logic [IMM_W-1:0]      imm;
    logic [SP_W-1:0]       sp_data;
    logic [REG_ADDR_W-1:0] addr_write_reg;
    logic                  memory_read;
    logic                  memory_write;
    logic                  reg_write_en;
    logic                  wb_mux_sel;
    logic                  call_flag;
    logic                  ret_flag;
    logic                  jmp_flag;
  } ex_mem_t;

endpackage

// File: rtl/stage3_int_alu.sv
// Combinational integer ALU. Output is forced to zero when not enabled.
// Optional signed divider is built only when DIV_UNIT_EN is defined.
module stage3_int_alu
  import stage3_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_fn_t           fn,
  input  logic              en,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] div_q;

`ifdef DIV_UNIT_EN
  // Signed quotient with defined results for divide-by-zero and the overflow case
  always_comb begin
    div_q = '0;
    if (b == '0) begin
      div_q = '1;
    end else if ((a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1)) begin
      div_q = a;
    end else begin
      div_q = DATA_W'($signed(a) / $signed(b));
    end
  end
`else
  assign div_q = '0;
`endif

  // Function decode; low product bits are identical for signed and unsigned multiply
  always_comb begin
    result = '0;
    if (en) begin
      case (fn)
        FN_ADD:          result = a + b;
        FN_SUB:          result = a - b;
        FN_MUL:          result = DATA_W'(a * b);
        FN_DIV:          result = div_q;
        FN_AND:          result = a & b;
        FN_OR:           result = a | b;
        FN_NOR:          result = ~(a | b);
        FN_XOR:          result = a ^ b;
        FN_SLL, FN_SLA:  result = a << b[4:0];
        FN_SRL:          result = a >> b[4:0];
        FN_SRA:          result = DATA_W'($signed(a) >>> b[4:0]);
        default:         result = '0;
      endcase
    end
  end

endmodule

// File: rtl/stage3_execute.sv
// MIPS execute stage: operand-B select, integer ALU, branch compare and
// EX/MEM pipeline register. Optional divider: define DIV_UNIT_EN.
module stage3_execute
  import stage3_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_W-1:0]   ALU_Op_Code,
  input  logic                  ALU_src,
  input  logic                  En_Integer,
  input  logic                  En_Float,
  input  logic [DATA_W-1:0]     data1_in,
  input  logic [DATA_W-1:0]     data2_in,
  input  logic [IMM_W-1:0]      imm_in,
  input  logic [SP_W-1:0]       SP_Data,
  input  logic [REG_ADDR_W-1:0] Addr_Write_Reg_in,
  input  logic                  Memory_Read_in,
  input  logic                  Memory_Write_in,
  input  logic                  Reg_Write_En_in,
  input  logic                  WB_Mux_sel_in,
  input  logic                  CALL_flag_in,
  input  logic                  RET_flag_in,
  input  logic                  JMP_flag_in,
  input  logic                  BR_flag_in,
  output logic [DATA_W-1:0]     Result_out,
  output logic [DATA_W-1:0]     Result_out_no_Pipeline,
  output logic                  BR_Ex_out,
  output logic [DATA_W-1:0]     data1_out,
  output logic [IMM_W-1:0]      imm_out,
  output logic [SP_W-1:0]       SP_Data_out,
  output logic [REG_ADDR_W-1:0] Addr_Write_Reg_out,
  output logic                  Memory_Read_out,
  output logic                  Memory_Write_out,
  output logic                  Reg_Write_En_out,
  output logic                  WB_Mux_sel_out,
  output logic                  CALL_flag_out,
  output logic                  RET_flag_out,
  output logic                  JMP_flag_out
);

  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] alu_result;
  alu_fn_t           fn;
  ex_mem_t           ex_mem_d;
  ex_mem_t           ex_mem_q;
  logic              unused_ok;

  // Immediate form only selects the operand source; float has no unit here
  assign unused_ok = ^{En_Float, ALU_Op_Code[IMM_BIT]};
  assign fn        = ALU_Op_Code[FN_W-1:0];
  assign operand_b = ALU_src ? {imm_in, {(DATA_W-IMM_W){1'b0}}} : data2_in;

  stage3_int_alu u_int_alu (
    .a      (data1_in),
    .b      (operand_b),
    .fn     (fn),
    .en     (En_Integer),
    .result (alu_result)
  );

  assign Result_out_no_Pipeline = alu_result;

  // Assemble next EX/MEM contents
  always_comb begin
    ex_mem_d                = '0;
    ex_mem_d.result         = alu_result;
    ex_mem_d.br_ex          = BR_flag_in & (data1_in == data2_in);
    ex_mem_d.data1          = data1_in;
    ex_mem_d.imm            = imm_in;
    ex_mem_d.sp_data        = SP_Data;
    ex_mem_d.addr_write_reg = Addr_Write_Reg_in;
    ex_mem_d.memory_read    = Memory_Read_in;
    ex_mem_d.memory_write   = Memory_Write_in;
    ex_mem_d.reg_write_en   = Reg_Write_En_in;
    ex_mem_d.wb_mux_sel     = WB_Mux_sel_in;
    ex_mem_d.call_flag      = CALL_flag_in;
    ex_mem_d.ret_flag       = RET_flag_in;
    ex_mem_d.jmp_flag       = JMP_flag_in;
  end

  // EX/MEM pipeline register, updates every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign Result_out         = ex_mem_q.result;
  assign BR_Ex_out          = ex_mem_q.br_ex;
  assign data1_out          = ex_mem_q.data1;
  assign imm_out            = ex_mem_q.imm;
  assign SP_Data_out        = ex_mem_q.sp_data;
  assign Addr_Write_Reg_out = ex_mem_q.addr_write_reg;
  assign Memory_Read_out    = ex_mem_q.memory_read;
  assign Memory_Write_out   = ex_mem_q.memory_write;
  assign Reg_Write_En_out   = ex_mem_q.reg_write_en;
  assign WB_Mux_sel_out     = ex_mem_q.wb_mux_sel;
  assign CALL_flag_out      = ex_mem_q.call_flag;
  assign RET_flag_out       = ex_mem_q.ret_flag;
  assign JMP_flag_out       = ex_mem_q.jmp_flag;

endmodule

// File: tb/tb_stage3_execute.sv
// Self-checking bench for stage3_execute (scoreboard of expected EX/MEM contents).
module tb_stage3_execute;

  logic        clk;
  logic        reset;
  logic [5:0]  ALU_Op_Code;
  logic        ALU_src;
  logic        En_Integer;
  logic        En_Float;
  logic [31:0] data1_in;
  logic [31:0] data2_in;
  logic [15:0] imm_in;
  logic [7:0]  SP_Data;
  logic [4:0]  Addr_Write_Reg_in;
  logic        Memory_Read_in, Memory_Write_in, Reg_Write_En_in, WB_Mux_sel_in;
  logic        CALL_flag_in, RET_flag_in, JMP_flag_in, BR_flag_in;
  logic [31:0] Result_out;
  logic [31:0] Result_out_no_Pipeline;
  logic        BR_Ex_out;
  logic [31:0] data1_out;
  logic [15:0] imm_out;
  logic [7:0]  SP_Data_out;
  logic [4:0]  Addr_Write_Reg_out;
  logic        Memory_Read_out, Memory_Write_out, Reg_Write_En_out, WB_Mux_sel_out;
  logic        CALL_flag_out, RET_flag_out, JMP_flag_out;

  typedef struct packed {
    logic [31:0] result;
    logic        br;
    logic [31:0] data1;
    logic [15:0] imm;
    logic [7:0]  sp;
    logic [4:0]  addr;
    logic [6:0]  ctrl;  // {mem_rd, mem_wr, reg_wr, wb_sel, call, ret, jmp}
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef DIV_UNIT_EN
  localparam logic DIV_ON = 1'b1;
`else
  localparam logic DIV_ON = 1'b0;
`endif

  stage3_execute dut (
    .clk(clk), .reset(reset), .ALU_Op_Code(ALU_Op_Code), .ALU_src(ALU_src),
    .En_Integer(En_Integer), .En_Float(En_Float), .data1_in(data1_in), .data2_in(data2_in),
    .imm_in(imm_in), .SP_Data(SP_Data), .Addr_Write_Reg_in(Addr_Write_Reg_in),
    .Memory_Read_in(Memory_Read_in), .Memory_Write_in(Memory_Write_in),
    .Reg_Write_En_in(Reg_Write_En_in), .WB_Mux_sel_in(WB_Mux_sel_in),
    .CALL_flag_in(CALL_flag_in), .RET_flag_in(RET_flag_in), .JMP_flag_in(JMP_flag_in),
    .BR_flag_in(BR_flag_in), .Result_out(Result_out),
    .Result_out_no_Pipeline(Result_out_no_Pipeline), .BR_Ex_out(BR_Ex_out),
    .data1_out(data1_out), .imm_out(imm_out), .SP_Data_out(SP_Data_out),
    .Addr_Write_Reg_out(Addr_Write_Reg_out), .Memory_Read_out(Memory_Read_out),
    .Memory_Write_out(Memory_Write_out), .Reg_Write_En_out(Reg_Write_En_out),
    .WB_Mux_sel_out(WB_Mux_sel_out), .CALL_flag_out(CALL_flag_out),
    .RET_flag_out(RET_flag_out), .JMP_flag_out(JMP_flag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation at the falling edge and record what EX/MEM must hold after the next rise
  task automatic drive_op(input logic [5:0] op, input logic src, input logic [31:0] a,
                          input logic [31:0] b, input logic [15:0] imm, input logic en_int,
                          input logic en_flt, input logic br, input logic [7:0] sp,
                          input logic [4:0] addr, input logic [6:0] ctrl,
                          input logic [31:0] exp_result);
    exp_t e;
    @(negedge clk);
    ALU_Op_Code = op; ALU_src = src; data1_in = a; data2_in = b; imm_in = imm;
    En_Integer = en_int; En_Float = en_flt; BR_flag_in = br; SP_Data = sp;
    Addr_Write_Reg_in = addr;
    {Memory_Read_in, Memory_Write_in, Reg_Write_En_in, WB_Mux_sel_in,
     CALL_flag_in, RET_flag_in, JMP_flag_in} = ctrl;
    e.result = exp_result;
    e.br     = br && (a == b);
    e.data1  = a;
    e.imm    = imm;
    e.sp     = sp;
    e.addr   = addr;
    e.ctrl   = ctrl;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    ALU_Op_Code = 6'b000100; ALU_src = 1'b0; En_Integer = 1'b1; En_Float = 1'b1;
    data1_in = 32'd1; data2_in = 32'd1; imm_in = 16'hFFFF; SP_Data = 8'hFF;
    Addr_Write_Reg_in = 5'h1F; BR_flag_in = 1'b1;
    {Memory_Read_in, Memory_Write_in, Reg_Write_En_in, WB_Mux_sel_in,
     CALL_flag_in, RET_flag_in, JMP_flag_in} = 7'h7F;
    @(posedge clk); #1;
    checks++;
    if ({Result_out, BR_Ex_out, data1_out, imm_out, SP_Data_out, Addr_Write_Reg_out} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%b/%h/%h/%h/%h want all zero", Result_out, BR_Ex_out,
               data1_out, imm_out, SP_Data_out, Addr_Write_Reg_out);
    end
    checks++;
    if ({Memory_Read_out, Memory_Write_out, Reg_Write_En_out, WB_Mux_sel_out,
         CALL_flag_out, RET_flag_out, JMP_flag_out} !== 7'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000", {Memory_Read_out, Memory_Write_out,
               Reg_Write_En_out, WB_Mux_sel_out, CALL_flag_out, RET_flag_out, JMP_flag_out});
    end
    checks++;
    if (Result_out_no_Pipeline !== 32'd2) begin
      errors++;
      $display("FAIL reset_comb: got %h want 00000002", Result_out_no_Pipeline);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Table-driven ALU cases: comb result checked same cycle, registered result one clock later
  task automatic run_table(input string name, input logic [5:0] ops[], input logic src,
                           input logic [31:0] as[], input logic [31:0] bs[],
                           input logic [15:0] imm, input logic [31:0] exps[]);
    exp_t e;
    for (int i = 0; i < ops.size(); i++) begin
      drive_op(ops[i], src, as[i], bs[i], imm, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 7'h00, exps[i]);
      #1;
      checks++;
      if (Result_out_no_Pipeline !== exps[i]) begin
        errors++;
        $display("FAIL %s_comb[%0d] op=%b: got %h want %h", name, i, ops[i],
                 Result_out_no_Pipeline, exps[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s_sb_empty[%0d]: got 0 entries want 1", name, i);
      end else begin
        e = sb.pop_front();
        if (Result_out !== e.result || BR_Ex_out !== e.br) begin
          errors++;
          $display("FAIL %s_reg[%0d] op=%b: got %h/%b want %h/%b", name, i, ops[i],
                   Result_out, BR_Ex_out, e.result, e.br);
        end
      end
    end
  endtask

  task automatic test_reg_ops();
    logic [5:0]  ops[]  = '{6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000111, 6'b000111,
                            6'b000110, 6'b000000};
    logic [31:0] as[]   = '{32'd15, 32'd15, 32'd15, 32'd15, 32'hFFFF_FFF1, 32'd15,
                            32'hFFFF_FFFD, 32'd15};
    logic [31:0] bs[]   = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd4, 32'd0, 32'd7, 32'd3};
    logic [31:0] exps[] = '{32'd18, 32'd12, 32'd45,
                            DIV_ON ? 32'd5 : 32'd0,
                            DIV_ON ? 32'hFFFF_FFFD : 32'd0,
                            DIV_ON ? 32'hFFFF_FFFF : 32'd0,
                            32'hFFFF_FFEB, 32'd0};
    run_table("regop", ops, 1'b0, as, bs, 16'h0000, exps);
  endtask

  task automatic test_div_overflow();
    logic [5:0]  ops[]  = '{6'b000111, 6'b100111};
    logic [31:0] as[]   = '{32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs[]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps[] = '{DIV_ON ? 32'h8000_0000 : 32'd0, DIV_ON ? 32'h8000_0000 : 32'd0};
    run_table("divovf", ops, 1'b0, as, bs, 16'h0000, exps);
  endtask

  task automatic test_logic();
    logic [5:0]  ops[]  = '{6'b001000, 6'b001001, 6'b001010, 6'b001011};
    logic [31:0] as[]   = '{32'h000F0F0F, 32'h000F0F0F, 32'h000F0F0F, 32'h000F0F0F};
    logic [31:0] bs[]   = '{32'h00000ABC, 32'h00000ABC, 32'h00000ABC, 32'h00000ABC};
    logic [31:0] exps[] = '{32'h00000A0C, 32'h000F0FBF, 32'hFFF0F040, 32'h000F05B3};
    run_table("logic", ops, 1'b0, as, bs, 16'h0000, exps);
  endtask

  task automatic test_shifts();
    logic [5:0]  ops[]  = '{6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b011011,
                            6'b011001, 6'b011000};
    logic [31:0] as[]   = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1};
    logic [31:0] bs[]   = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd4, 32'd4, 32'h0000_003F};
    logic [31:0] exps[] = '{32'd20, 32'd1, 32'd20, 32'd1, 32'hF800_0000, 32'h0800_0000,
                            32'h8000_0000};
    run_table("shift", ops, 1'b0, as, bs, 16'h0000, exps);
  endtask

  task automatic test_immediate();
    logic [5:0]  ops[]  = '{6'b100100, 6'b100101, 6'b101000, 6'b101001};
    logic [31:0] as[]   = '{32'h0F00_0000, 32'h0F00_0000, 32'h0F00_0000, 32'h0F00_0000};
    logic [31:0] bs[]   = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
    // Operand B becomes 0x003D0000, so AND with 0x0F000000 has no common bits
    logic [31:0] exps[] = '{32'h0F3D_0000, 32'h0EC3_0000, 32'h0000_0000, 32'h0F3D_0000};
    run_table("imm", ops, 1'b1, as, bs, 16'h003D, exps);
  endtask

  task automatic test_branch_enable();
    exp_t e;
    logic [31:0] a_v[]   = '{32'd7, 32'd7, 32'd7, 32'd9, 32'd9};
    logic [31:0] b_v[]   = '{32'd7, 32'd8, 32'd7, 32'd9, 32'd9};
    logic        br_v[]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        en_v[]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        flt_v[] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] r_v[]   = '{32'd14, 32'd15, 32'd14, 32'd0, 32'd0};
    logic        eb_v[]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive_op(6'b000100, 1'b0, a_v[i], b_v[i], 16'h0000, en_v[i], flt_v[i], br_v[i],
               8'h00, 5'd0, 7'h00, r_v[i]);
      #1;
      checks++;
      if (Result_out_no_Pipeline !== r_v[i]) begin
        errors++;
        $display("FAIL branch_comb[%0d]: got %h want %h", i, Result_out_no_Pipeline, r_v[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL branch_sb_empty[%0d]: got 0 entries want 1", i);
      end else begin
        e = sb.pop_front();
        if (BR_Ex_out !== eb_v[i] || Result_out !== e.result) begin
          errors++;
          $display("FAIL branch_reg[%0d]: got br=%b res=%h want br=%b res=%h", i,
                   BR_Ex_out, Result_out, eb_v[i], e.result);
        end
      end
    end
  endtask

  task automatic test_passthrough();
    exp_t e;
    logic [7:0]  sp_v[]   = '{8'h5A, 8'hA5, 8'h00};
    logic [4:0]  ad_v[]   = '{5'd17, 5'd2, 5'd31};
    logic [6:0]  ct_v[]   = '{7'h7F, 7'h55, 7'h2A};
    logic [31:0] d1_v[]   = '{32'hDEAD_BEEF, 32'h0000_0001, 32'h8000_0000};
    logic [15:0] im_v[]   = '{16'h1234, 16'hFFFF, 16'h8001};
    for (int i = 0; i < 3; i++) begin
      drive_op(6'b001001, 1'b0, d1_v[i], 32'h0, im_v[i], 1'b1, 1'b0, 1'b0,
               sp_v[i], ad_v[i], ct_v[i], d1_v[i]);
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pass_sb_empty[%0d]: got 0 entries want 1", i);
      end else begin
        e = sb.pop_front();
        if ({Result_out, data1_out, imm_out, SP_Data_out, Addr_Write_Reg_out} !==
            {e.result, e.data1, e.imm, e.sp, e.addr} ||
            {Memory_Read_out, Memory_Write_out, Reg_Write_En_out, WB_Mux_sel_out,
             CALL_flag_out, RET_flag_out, JMP_flag_out} !== e.ctrl) begin
          errors++;
          $display("FAIL pass[%0d]: got res=%h d1=%h imm=%h sp=%h addr=%0d ctrl=%b want res=%h d1=%h imm=%h sp=%h addr=%0d ctrl=%b",
                   i, Result_out, data1_out, imm_out, SP_Data_out, Addr_Write_Reg_out,
                   {Memory_Read_out, Memory_Write_out, Reg_Write_En_out, WB_Mux_sel_out,
                    CALL_flag_out, RET_flag_out, JMP_flag_out},
                   e.result, e.data1, e.imm, e.sp, e.addr, e.ctrl);
        end
      end
    end
  endtask

  // Asynchronous reset mid-stream clears registers without waiting for a clock edge
  task automatic test_async_reset();
    drive_op(6'b000100, 1'b0, 32'd100, 32'd100, 16'h0000, 1'b1, 1'b0, 1'b1,
             8'h11, 5'd3, 7'h7F, 32'd200);
    @(posedge clk); #1;
    void'(sb.pop_front());
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({Result_out, BR_Ex_out, SP_Data_out, Memory_Read_out} !== '0) begin
      errors++;
      $display("FAIL async_reset: got res=%h br=%b sp=%h rd=%b want all zero",
               Result_out, BR_Ex_out, SP_Data_out, Memory_Read_out);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_reg_ops();
    test_div_overflow();
    test_logic();
    test_shifts();
    test_immediate();
    test_branch_enable();
    test_passthrough();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
